// File: rtl/kill_the_bit_ctrl.sv
// Kill-the-bit game sequencer driving the TM1638 LED/key request port.
// Define KILL_THE_BIT_SCORE_EN to show the kill count on seg7 digits 6/7.
module kill_the_bit_ctrl #(
  parameter int unsigned CLOCK_FREQ_MHz = 12,
  parameter int unsigned STEP_MS        = 200,
  parameter logic [7:0]  INIT_PATTERN   = 8'b0000_0001,
  parameter logic [2:0]  BRIGHTNESS     = 3'd0
) (
  input  logic        i_clk,
  input  logic        rst_n,
  input  logic        i_idle,
  input  logic [7:0]  i_btn_state,
  output logic        o_cmd_en,
  output logic        o_all_led_en,
  output logic        o_btn_en,
  output logic        o_seg7_en,
  output logic [2:0]  o_idx,
  output logic [7:0]  o_data,
  output logic [27:0] o_wait_counter,
  output logic [7:0]  o_pattern,
  output logic [7:0]  o_kills,
  output logic        o_win
);
  localparam int unsigned STEP_CYCLES = CLOCK_FREQ_MHz * 1000 * STEP_MS;
  localparam logic [31:0] STEP_LAST   = 32'(STEP_CYCLES - 1);

  typedef enum logic [3:0] {
    S_MODE, S_ACT, S_SHOW, S_SC6, S_SC7,
    S_BTN, S_UPD, S_TICK, S_WIN
  } state_t;

  state_t      state_q, state_d;
  logic        wait_q, low_q, sent_q;
  logic [2:0]  cnt_q;
  logic        cmd_q, led_q, btn_q;
  logic [7:0]  data_q;
  logic [7:0]  pattern_q, pattern_d;
  logic [7:0]  prev_q, prev_d;
  logic [7:0]  kills_q, kills_d;
  logic        win_q, win_d;
  logic [31:0] timer_q, timer_d;

  logic        req_cmd, req_led, req_btn;
  logic [7:0]  req_data;
  logic        has_req, issue, done;
  logic [7:0]  edges, hits, upd_pat;
  logic [3:0]  hit_n;
  logic [8:0]  kill_sum;

`ifdef KILL_THE_BIT_SCORE_EN
  logic        req_seg, seg_q;
  logic [2:0]  req_idx, idx_q;
  logic [7:0]  rem100, tens, units;

  function automatic logic [7:0] seg7(input logic [7:0] d);
    unique case (d)
      8'd0:    seg7 = 8'h3f;
      8'd1:    seg7 = 8'h06;
      8'd2:    seg7 = 8'h5b;
      8'd3:    seg7 = 8'h4f;
      8'd4:    seg7 = 8'h66;
      8'd5:    seg7 = 8'h6d;
      8'd6:    seg7 = 8'h7d;
      8'd7:    seg7 = 8'h07;
      8'd8:    seg7 = 8'h7f;
      8'd9:    seg7 = 8'h6f;
      default: seg7 = 8'h00;
    endcase
  endfunction

  assign rem100 = kills_q % 8'd100;
  assign tens   = rem100 / 8'd10;
  assign units  = rem100 % 8'd10;
`endif

  always_comb begin
    req_cmd  = 1'b0;
    req_led  = 1'b0;
    req_btn  = 1'b0;
    req_data = 8'h00;
`ifdef KILL_THE_BIT_SCORE_EN
    req_seg  = 1'b0;
    req_idx  = 3'd0;
`endif
    unique case (state_q)
      S_MODE: begin
        req_cmd  = 1'b1;
        req_data = 8'h40;
      end
      S_ACT: begin
        req_cmd  = 1'b1;
        req_data = 8'h88 | {5'd0, BRIGHTNESS};
      end
      S_SHOW: begin
        req_led  = 1'b1;
        req_data = pattern_q;
      end
`ifdef KILL_THE_BIT_SCORE_EN
      S_SC6: begin
        req_seg  = 1'b1;
        req_idx  = 3'd6;
        req_data = seg7(tens);
      end
      S_SC7: begin
        req_seg  = 1'b1;
        req_idx  = 3'd7;
        req_data = seg7(units);
      end
`endif
      S_BTN: req_btn = 1'b1;
      S_WIN: begin
        req_led  = !sent_q;
        req_data = 8'hff;
      end
      default: ;
    endcase
  end

`ifdef KILL_THE_BIT_SCORE_EN
  assign has_req = req_cmd | req_led | req_btn | req_seg;
`else
  assign has_req = req_cmd | req_led | req_btn;
`endif
  assign issue = has_req && !wait_q && i_idle;
  // A request ends on idle after a busy period, or on idle after 4 quiet cycles.
  assign done  = wait_q && i_idle && (low_q || cnt_q == 3'd4);

  assign edges   = i_btn_state & ~prev_q;
  assign hits    = edges & pattern_q;
  assign upd_pat = pattern_q ^ edges;

  always_comb begin
    hit_n = 4'd0;
    for (int i = 0; i < 8; i++) hit_n = hit_n + {3'd0, hits[i]};
  end

  assign kill_sum = {1'b0, kills_q} + {5'd0, hit_n};

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    prev_d    = prev_q;
    kills_d   = kills_q;
    win_d     = win_q;
    timer_d   = timer_q;
    if (state_q inside {S_SHOW, S_SC6, S_SC7, S_BTN, S_UPD, S_TICK})
      timer_d = timer_q + 32'd1;
    unique case (state_q)
      S_MODE: if (done) state_d = S_ACT;
      S_ACT:  if (done) state_d = S_SHOW;
`ifdef KILL_THE_BIT_SCORE_EN
      S_SHOW: if (done) state_d = S_SC6;
`else
      S_SHOW: if (done) state_d = S_BTN;
`endif
      S_SC6:  if (done) state_d = S_SC7;
      S_SC7:  if (done) state_d = S_BTN;
      S_BTN:  if (done) state_d = S_UPD;
      S_UPD: begin
        prev_d  = i_btn_state;
        kills_d = kill_sum[8] ? 8'hff : kill_sum[7:0];
        if (upd_pat == 8'h00) begin
          pattern_d = 8'h00;
          win_d     = 1'b1;
          state_d   = S_WIN;
        end else begin
          pattern_d = upd_pat;
          state_d   = S_TICK;
        end
      end
      S_TICK: begin
        if (timer_q >= STEP_LAST) begin
          timer_d   = 32'd0;
          pattern_d = {pattern_q[6:0], pattern_q[7]};
          state_d   = S_SHOW;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_MODE;
      wait_q    <= 1'b0;
      low_q     <= 1'b0;
      sent_q    <= 1'b0;
      cnt_q     <= 3'd0;
      cmd_q     <= 1'b0;
      led_q     <= 1'b0;
      btn_q     <= 1'b0;
      data_q    <= 8'h00;
      pattern_q <= INIT_PATTERN;
      prev_q    <= 8'h00;
      kills_q   <= 8'h00;
      win_q     <= 1'b0;
      timer_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      prev_q    <= prev_d;
      kills_q   <= kills_d;
      win_q     <= win_d;
      timer_q   <= timer_d;
      cmd_q     <= issue & req_cmd;
      led_q     <= issue & req_led;
      btn_q     <= issue & req_btn;
      if (issue) begin
        data_q <= req_data;
        wait_q <= 1'b1;
        cnt_q  <= 3'd0;
        low_q  <= 1'b0;
      end else if (wait_q) begin
        if (done) wait_q <= 1'b0;
        if (cnt_q != 3'd4) cnt_q <= cnt_q + 3'd1;
        if (cnt_q != 3'd0 && !i_idle) low_q <= 1'b1;
      end
      if (issue && state_q == S_WIN) sent_q <= 1'b1;
    end
  end

`ifdef KILL_THE_BIT_SCORE_EN
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 1'b0;
      idx_q <= 3'd0;
    end else begin
      seg_q <= issue & req_seg;
      if (issue) idx_q <= req_idx;
    end
  end

  assign o_seg7_en = seg_q;
  assign o_idx     = idx_q;
`else
  assign o_seg7_en = 1'b0;
  assign o_idx     = 3'd0;
`endif

  assign o_cmd_en       = cmd_q;
  assign o_all_led_en   = led_q;
  assign o_btn_en       = btn_q;
  assign o_data         = data_q;
  assign o_wait_counter = 28'd0;
  assign o_pattern      = pattern_q;
  assign o_kills        = kills_q;
  assign o_win          = win_q;
endmodule
